// File: rtl/satalnk_pkg.sv
// Shared SATA link-layer constants: primitives, scrambler/CRC seeds and
// polynomials, and the TX framer state encoding.
package satalnk_pkg;

  localparam logic [32:0] P_SYNC  = 33'h17c95b5b5;
  localparam logic [32:0] P_SOF   = 33'h17cb53737;
  localparam logic [32:0] P_EOF   = 33'h17cb5d5d5;
  localparam logic [32:0] P_HOLD  = 33'h17caad5d5;
  localparam logic [32:0] P_ALIGN = 33'h1bc4a4a7b;
  localparam logic [32:0] P_CONT  = 33'h17caa9999;

  localparam logic [15:0] SCR_SEED = 16'hffff;
  localparam logic [15:0] SCR_POLY = 16'ha011;
  localparam logic [31:0] CRC_SEED = 32'h52325032;
  localparam logic [31:0] CRC_POLY32 = 32'h04c11db7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOF  = 3'd1,
    S_DATA = 3'd2,
    S_CRC  = 3'd3,
    S_EOF  = 3'd4
  } txf_state_t;

endpackage

// File: rtl/satalnk_scrambler.sv
// SATA scrambler: 16-bit LFSR stepped 32 times per DWORD, mask taken
// MSB-first. Shared by the TX framer and the RX descrambler.
module satalnk_scrambler
  import satalnk_pkg::*;
#(
  parameter logic        OPT_LITTLE_ENDIAN = 1'b0,
  parameter logic [15:0] SEED              = SCR_SEED,
  parameter logic [15:0] POLY              = SCR_POLY
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_advance,
  output logic [31:0] o_mask
);

  logic [15:0] fill_q, fill_d;
  logic [31:0] raw;

  always_comb begin
    fill_d = fill_q;
    raw    = '0;
    for (int k = 0; k < 32; k++) begin
      raw[31-k] = fill_d[15];
      fill_d    = {fill_d[14:0], 1'b0} ^ (fill_d[15] ? POLY : 16'h0000);
    end
  end

  // The inserter consumes bytes in wire order, so big-endian builds swap.
  assign o_mask = OPT_LITTLE_ENDIAN ? raw
                                    : {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};

  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      fill_q <= SEED;
    end else if (i_advance) begin
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/satalnk_txframe.sv
// SATA link-layer TX framer: SYNC fill, SOF, scrambled payload + CRC, EOF,
// HOLD on starvation. Optional macro SATALNK_TXFRAME_CRCERR_EN adds i_cfg_crc_err.
module satalnk_txframe
  import satalnk_pkg::*;
#(
  parameter logic        OPT_LITTLE_ENDIAN = 1'b0,
  parameter logic [15:0] INITIAL_SCRAMBLER = 16'hffff,
  parameter logic [15:0] SCRAMBLER_POLY    = 16'ha011,
  parameter logic [31:0] CRC_POLY          = 32'h04c11db7,
  parameter logic [31:0] INITIAL_CRC       = 32'h52325032,
  parameter logic [32:0] PRIM_SYNC         = P_SYNC,
  parameter logic [32:0] PRIM_SOF          = P_SOF,
  parameter logic [32:0] PRIM_EOF          = P_EOF,
  parameter logic [32:0] PRIM_HOLD         = P_HOLD
) (
  input  logic        i_clk,
  input  logic        i_reset,
`ifdef SATALNK_TXFRAME_CRCERR_EN
  input  logic        i_cfg_crc_err,
`endif
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        m_ready,
  output logic [32:0] m_data,
  output logic        o_busy
);

  txf_state_t  state_q, state_d;
  logic [32:0] m_data_q, m_data_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_out;
  logic [31:0] mask;
  logic        scr_load, scr_adv;

  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

`ifdef SATALNK_TXFRAME_CRCERR_EN
  assign crc_out = crc_q ^ {32{i_cfg_crc_err}};
`else
  assign crc_out = crc_q;
`endif

  satalnk_scrambler #(
    .OPT_LITTLE_ENDIAN (OPT_LITTLE_ENDIAN),
    .SEED              (INITIAL_SCRAMBLER),
    .POLY              (SCRAMBLER_POLY)
  ) u_scrambler (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (scr_load),
    .i_advance (scr_adv),
    .o_mask    (mask)
  );

  // Nothing moves unless the inserter takes the current word.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    crc_d    = crc_q;
    scr_load = 1'b0;
    scr_adv  = 1'b0;
    if (m_ready) begin
      case (state_q)
        S_IDLE: begin
          m_data_d = PRIM_SYNC;
          if (s_valid) state_d = S_SOF;
        end
        S_SOF: begin
          m_data_d = PRIM_SOF;
          crc_d    = INITIAL_CRC;
          scr_load = 1'b1;
          state_d  = S_DATA;
        end
        S_DATA: begin
          if (s_valid) begin
            m_data_d = {1'b0, s_data ^ mask};
            crc_d    = crc32_step(crc_q, s_data);
            scr_adv  = 1'b1;
            if (s_last) state_d = S_CRC;
          end else begin
            m_data_d = PRIM_HOLD;
          end
        end
        S_CRC: begin
          m_data_d = {1'b0, crc_out ^ mask};
          scr_adv  = 1'b1;
          state_d  = S_EOF;
        end
        S_EOF: begin
          m_data_d = PRIM_EOF;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      m_data_q <= PRIM_SYNC;
      crc_q    <= INITIAL_CRC;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      crc_q    <= crc_d;
    end
  end

  assign s_ready = m_ready && (state_q == S_DATA);
  assign m_data  = m_data_q;
  assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_satalnk_txframe.sv
// Self-checking bench for satalnk_txframe: expected output words are queued
// as stimulus is driven and popped after each clock edge.
module tb_satalnk_txframe;

  localparam logic [32:0] SYNC = 33'h17c95b5b5;
  localparam logic [32:0] SOF  = 33'h17cb53737;
  localparam logic [32:0] EOF  = 33'h17cb5d5d5;
  localparam logic [32:0] HOLD = 33'h17caad5d5;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last, m_ready, busy;
  logic [31:0] s_data;
  logic [32:0] m_data;
  logic        cfg_err;

  logic [32:0] exp_q[$];
  logic [32:0] last_exp;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  satalnk_txframe dut (
    .i_clk         (clk),
    .i_reset       (rst),
`ifdef SATALNK_TXFRAME_CRCERR_EN
    .i_cfg_crc_err (cfg_err),
`endif
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .o_busy        (busy)
  );

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] g_mask(input logic [15:0] s);
    logic [15:0] f;
    logic [31:0] r;
    f = s;
    for (int k = 0; k < 32; k++) begin
      r[31-k] = f[15];
      f = f[15] ? ({f[14:0], 1'b0} ^ 16'ha011) : {f[14:0], 1'b0};
    end
    return {r[7:0], r[15:8], r[23:16], r[31:24]};
  endfunction

  function automatic logic [15:0] g_adv(input logic [15:0] s);
    logic [15:0] f;
    f = s;
    for (int k = 0; k < 32; k++)
      f = f[15] ? ({f[14:0], 1'b0} ^ 16'ha011) : {f[14:0], 1'b0};
    return f;
  endfunction

  function automatic logic [31:0] g_crc(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--)
      r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ 32'h04c11db7) : {r[30:0], 1'b0};
    return r;
  endfunction

  // One clock: drive inputs, check s_ready, then check the word after the edge.
  task automatic step(input logic mr, input logic sv, input logic [31:0] sd,
                      input logic sl, input logic [32:0] exp_m, input logic exp_sr,
                      input string tag);
    logic [32:0] e;
    m_ready = mr; s_valid = sv; s_data = sd; s_last = sl;
    #1;
    chk({tag, "/s_ready"}, 33'(s_ready), 33'(exp_sr));
    exp_q.push_back((mr || rst) ? exp_m : last_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "/m_data"}, m_data, e);
    last_exp = e;
  endtask

  task automatic run_frame(input logic [31:0] pl[$], input int gap_at, input int gap_len,
                           input logic stalls, input string tag);
    logic [15:0] scr;
    logic [31:0] crc;
    int          n;
    scr = 16'hffff;
    crc = 32'h52325032;
    n   = pl.size();
    step(1'b1, 1'b1, pl[0], n == 1, SYNC, 1'b0, {tag, ":idle"});
    chk({tag, ":busy_sof"}, 33'(busy), 33'd1);
    if (stalls) repeat (2) step(1'b0, 1'b1, pl[0], n == 1, SYNC, 1'b0, {tag, ":stall_sof"});
    step(1'b1, 1'b1, pl[0], n == 1, SOF, 1'b0, {tag, ":sof"});
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) repeat (gap_len) step(1'b1, 1'b0, 32'h0, 1'b0, HOLD, 1'b1, {tag, ":hold"});
      if (stalls && i == 1)
        repeat (2) step(1'b0, 1'b1, pl[i], i == n - 1, SYNC, 1'b0, {tag, ":stall_data"});
      step(1'b1, 1'b1, pl[i], i == n - 1, {1'b0, pl[i] ^ g_mask(scr)}, 1'b1, {tag, ":data"});
      crc = g_crc(crc, pl[i]);
      scr = g_adv(scr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, {1'b0, (crc ^ {32{cfg_err}}) ^ g_mask(scr)}, 1'b0, {tag, ":crc"});
    if (stalls) repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, SYNC, 1'b0, {tag, ":stall_eof"});
    step(1'b1, 1'b0, 32'h0, 1'b0, EOF, 1'b0, {tag, ":eof"});
    step(1'b1, 1'b0, 32'h0, 1'b0, SYNC, 1'b0, {tag, ":sync"});
    chk({tag, ":busy_end"}, 33'(busy), 33'd0);
  endtask

  initial begin
    logic [31:0] one[$];
    logic [31:0] four[$];
    logic [31:0] five[$];
    logic [15:0] scr;

    rst = 1'b1; cfg_err = 1'b0;
    m_ready = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/m_data", m_data, SYNC);
    chk("reset/busy", 33'(busy), 33'd0);
    chk("reset/s_ready", 33'(s_ready), 33'd0);
    rst = 1'b0;
    last_exp = SYNC;

    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, SYNC, 1'b0, "idle");
      chk("idle/busy", 33'(busy), 33'd0);
    end

    one  = '{32'h00000000};
    four = '{32'h11223344, 32'hdeadbeef, 32'h00000001, 32'h80000000};
    five = '{32'hcafef00d, 32'h12345678, 32'hffffffff, 32'h0badc0de, 32'h5a5aa5a5};

    run_frame(one, -1, 0, 1'b0, "one");
    run_frame(four, -1, 0, 1'b0, "four");
    run_frame(four, 2, 3, 1'b0, "four_gap");
    run_frame(four, -1, 0, 1'b1, "four_stall");

    // Abort a frame with reset while the third payload beat is presented.
    scr = 16'hffff;
    step(1'b1, 1'b1, five[0], 1'b0, SYNC, 1'b0, "abort:idle");
    step(1'b1, 1'b1, five[0], 1'b0, SOF, 1'b0, "abort:sof");
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, five[i], 1'b0, {1'b0, five[i] ^ g_mask(scr)}, 1'b1, "abort:data");
      scr = g_adv(scr);
    end
    rst = 1'b1;
    step(1'b1, 1'b1, five[2], 1'b0, SYNC, 1'b1, "abort:reset");
    rst = 1'b0;
    chk("abort:busy", 33'(busy), 33'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, SYNC, 1'b0, "abort:idle2");
    run_frame(five, -1, 0, 1'b0, "after_abort");

`ifdef SATALNK_TXFRAME_CRCERR_EN
    cfg_err = 1'b1;
    run_frame(four, -1, 0, 1'b0, "crcerr");
    cfg_err = 1'b0;
    run_frame(four, -1, 0, 1'b0, "crc_ok");
`endif

    run_frame(one, 0, 2, 1'b0, "one_gap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
